ysyx_23060240_mc_ctrl: RTL and testbench
========================================

# ysyx_23060240_mc_ctrl

Multi-cycle execution sequencer and PC owner for the next-generation NPC core. It replaces the single-cycle PC register with a state machine that fetches instructions over a valid/ready bus, holds each instruction stable through decode and execute, and drives load/store requests over a second valid/ready bus. It gates register and CSR writeback to a single commit cycle and halts on bus errors, timeouts or misaligned targets. It sits between the IFU/LSU bus ports and the existing IDU/ALU/RegisterFile/CSR datapath.

## Interface
- XLEN, 32, PC and address width.
- RESET_PC, 32'h8000_0000, PC value loaded at reset.
- TIMEOUT_CYCLES, 255, maximum cycles in any bus REQ/WAIT state; 0 disables the timeout.

- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-low
- ifu_req_valid  output  1  fetch request valid
- ifu_req_addr  output  XLEN  fetch address, always equal to pc
- ifu_req_ready  input  1  fetch request accepted
- ifu_rsp_valid  input  1  fetch data valid
- ifu_rsp_data  input  32  fetched instruction
- ifu_rsp_err  input  1  fetch bus error, qualified by ifu_rsp_valid
- inst  output  32  latched instruction, feeds the IDU
- pc  output  XLEN  PC of the instruction in flight
- is_load, is_store  input  1 each  IDU decode of inst
- jump_en  input  1  branch or jal/jalr taken
- jump_pc  input  XLEN  jump target
- trap_en  input  1  ecall/mret redirect
- trap_pc  input  XLEN  CSR-supplied target
- lsu_req_valid  output  1  load/store request valid
- lsu_req_ready  input  1  LSU request accepted
- lsu_rsp_valid  input  1  LSU done; load data valid
- lsu_rsp_err  input  1  LSU bus error, qualified by lsu_rsp_valid
- gpr_w_gate  output  1  AND-gate for the RegisterFile w_en
- csr_w_gate  output  1  AND-gate for the CSR w_csr_en
- commit  output  1  one-cycle pulse per retired instruction
- halted  output  1  sticky halt flag
- err_cause  output  3  0 none, 1 fetch err, 2 LSU err, 3 timeout, 4 misaligned PC

## Operation
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- FETCH_REQ:
  - ifu_req_valid=1.
  - On ifu_req_ready, go to FETCH_WAIT.
  - ifu_rsp_valid is ignored in this state.
- FETCH_WAIT:
  - On ifu_rsp_valid with err, go to HALT with cause 1.
  - On ifu_rsp_valid without err, inst<=ifu_rsp_data and go to EXEC.
- EXEC (always 1 cycle):
  - If is_load|is_store, go to MEM_REQ.
  - Otherwise go to WB.
- MEM_REQ:
  - lsu_req_valid=1.
  - On lsu_req_ready, go to MEM_WAIT.
- MEM_WAIT:
  - On lsu_rsp_valid with err, go to HALT with cause 2.
  - On lsu_rsp_valid without err, go to WB.
- WB (1 cycle):
  - gpr_w_gate=csr_w_gate=commit=1.
  - Next PC is chosen by priority: trap_pc if trap_en, else jump_pc if jump_en, else pc+4 (mod 2^XLEN, wraps).
  - If next PC[1:0]!=0: pc is still updated, commit still pulses, then go to HALT with cause 4.
  - Otherwise go to FETCH_REQ.
- HALT: absorbing until reset. halted=1, err_cause held, no bus requests, all gates 0.
- Timeout:
  - The counter clears on every state entry and increments each cycle spent in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT.
  - When the count reaches TIMEOUT_CYCLES without the exit condition, go to HALT with cause 3.
  - If the exit condition and the timeout occur in the same cycle, the exit condition wins.
- Request stability: ifu_req_addr is stable while ifu_req_valid=1. Valid is not dropped before ready.
- inst and pc are stable from EXEC through WB. Decode inputs are sampled only in EXEC (is_load/is_store) and in WB (jump/trap).
- Gates are 0 in every state other than WB, so datapath writes occur exactly once per instruction.

## Timing
- While rst=0: state<=FETCH_REQ, pc<=RESET_PC, inst<=32'h0000_0013 (nop), err_cause<=0, halted<=0, timeout counter<=0.
- Outputs while rst=0: ifu_req_valid, lsu_req_valid, gates and commit are all 0. These outputs are decoded from the registered state and the held rst.
- First cycle after rst rises: ifu_req_valid=1, ifu_req_addr=RESET_PC.
- Reset asserted mid-operation: any in-flight bus transaction is abandoned and the first edge with rst=0 applies reset values. Bus slaves must be reset together with this block.
- Zero-wait buses (ready on the request cycle, response the next cycle):
  - Non-memory instruction: 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB).
  - Load/store: 6 cycles.
- commit rises in WB. The new pc is visible the cycle after WB, together with ifu_req_valid.

## Test plan
- Reset and sequential fetch: hold rst=0 for 3 cycles, release, zero-wait IFU returning nop at each address -> first ifu_req_addr=8000_0000, commit every 4th cycle, pc sequence 8000_0000, 8000_0004, 8000_0008.
- Stalled handshakes: ifu_req_ready low for 5 cycles, then lsu_rsp_valid delayed 7 cycles on a load -> ifu_req_addr stable throughout, exactly one gpr_w_gate pulse, commit after 1+5+1+1+1+7+1 cycle count.
- Redirect priority: trap_en=1 with trap_pc=8000_0100 and jump_en=1 with jump_pc=8000_0200 in the same WB -> next ifu_req_addr=8000_0100; with jump only -> 8000_0200.
- Errors: ifu_rsp_err on the second fetch -> halted=1, err_cause=1, no further requests for 50 cycles, commit count=1; repeat with lsu_rsp_err -> err_cause=2.
- Timeout and misalignment:
  - TIMEOUT_CYCLES=8, ifu_req_ready never asserted -> HALT entered after 8 cycles in FETCH_REQ, err_cause=3.
  - jump_pc=8000_0102 -> commit pulses, pc=8000_0102, err_cause=4.
- Reset mid-MEM_WAIT: assert rst during an outstanding load -> next cycle pc=8000_0000, all gates 0, lsu_req_valid=0, fresh fetch after release.

Source files
------------

// File: rtl/ysyx_23060240_mc_ctrl.sv
// ysyx_23060240_mc_ctrl
// Multi-cycle execution sequencer and PC owner. Fetches each instruction over
// a valid/ready bus, holds it stable through decode/execute, issues load/store
// requests over a second valid/ready bus, and opens the register/CSR write
// gates for exactly one commit cycle per instruction. Bus errors, bus
// timeouts and misaligned next-PC values park the core in a sticky HALT state.
module ysyx_23060240_mc_ctrl #(
  parameter int unsigned      XLEN           = 32,
  parameter logic [XLEN-1:0]  RESET_PC       = XLEN'(32'h8000_0000),
  parameter int unsigned      TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,

  // Instruction fetch bus
  output logic            ifu_req_valid,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_req_ready,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_data,
  input  logic            ifu_rsp_err,

  // Instruction in flight, towards the IDU
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,

  // Decode / redirect information from the datapath
  input  logic            is_load,
  input  logic            is_store,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_pc,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,

  // Load/store bus
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_rsp_valid,
  input  logic            lsu_rsp_err,

  // Commit control and status
  output logic            gpr_w_gate,
  output logic            csr_w_gate,
  output logic            commit,
  output logic            halted,
  output logic [2:0]      err_cause
);

  typedef enum logic [2:0] {
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NONE      = 3'd0,
    C_FETCH_ERR = 3'd1,
    C_LSU_ERR   = 3'd2,
    C_TIMEOUT   = 3'd3,
    C_MISALIGN  = 3'd4
  } cause_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t          state;
  logic [31:0]     tmo_cnt;
  logic            tmo_hit;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;
  logic            in_wb;

  // The counter holds the number of cycles already spent in the current bus
  // state, so the cycle that would make it reach the limit is the one that
  // times out. A limit of zero disables the check entirely.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TIMEOUT_CYCLES - 32'd1);

  // Redirect priority: trap beats jump beats sequential; pc+4 wraps naturally.
  assign next_pc = trap_en ? trap_pc :
                   jump_en ? jump_pc :
                             pc + XLEN'(4);
  assign next_misaligned = (next_pc[1:0] != 2'b00);

  // Bus requests and write gates are decoded from the registered state and
  // forced low while reset is held, so nothing leaks out during reset.
  assign in_wb         = rst && (state == S_WB);
  assign ifu_req_valid = rst && (state == S_FETCH_REQ);
  assign lsu_req_valid = rst && (state == S_MEM_REQ);
  assign ifu_req_addr  = pc;
  assign gpr_w_gate    = in_wb;
  assign csr_w_gate    = in_wb;
  assign commit        = in_wb;

  // Sequencer: state, PC, latched instruction, timeout counter and halt status.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register, independent of order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_FETCH_REQ;
      pc        <= RESET_PC;
      inst      <= NOP_INST;
      err_cause <= C_NONE;
      halted    <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      // Any state change clears the counter; staying in a bus state bumps it.
      tmo_cnt <= '0;
      case (state)
        S_FETCH_REQ: begin
          // A response arriving before the request is accepted is ignored.
          if (ifu_req_ready) begin
            state <= S_FETCH_WAIT;
          end else if (tmo_hit) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            err_cause <= C_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        S_FETCH_WAIT: begin
          if (ifu_rsp_valid) begin
            if (ifu_rsp_err) begin
              state     <= S_HALT;
              halted    <= 1'b1;
              err_cause <= C_FETCH_ERR;
            end else begin
              inst  <= ifu_rsp_data;
              state <= S_EXEC;
            end
          end else if (tmo_hit) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            err_cause <= C_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        S_EXEC: begin
          state <= (is_load || is_store) ? S_MEM_REQ : S_WB;
        end

        S_MEM_REQ: begin
          if (lsu_req_ready) begin
            state <= S_MEM_WAIT;
          end else if (tmo_hit) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            err_cause <= C_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        S_MEM_WAIT: begin
          if (lsu_rsp_valid) begin
            if (lsu_rsp_err) begin
              state     <= S_HALT;
              halted    <= 1'b1;
              err_cause <= C_LSU_ERR;
            end else begin
              state <= S_WB;
            end
          end else if (tmo_hit) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            err_cause <= C_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        S_WB: begin
          // The instruction retires even when its successor target is bad;
          // the bad PC stays visible for debug while the core sits in HALT.
          pc <= next_pc;
          if (next_misaligned) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            err_cause <= C_MISALIGN;
          end else begin
            state <= S_FETCH_REQ;
          end
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_mc_ctrl.sv
// Self-checking bench for ysyx_23060240_mc_ctrl. Each instruction is
// described by a transaction record (bus stall lengths, memory kind, errors,
// redirects); the bench walks the expected phase sequence cycle by cycle,
// acting as both bus slaves, and derives the expected PC stream from the
// architectural redirect rules.
module tb_ysyx_23060240_mc_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TMO    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready = 1'b0;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_data  = '0;
  logic        ifu_rsp_err   = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        is_load  = 1'b0;
  logic        is_store = 1'b0;
  logic        jump_en  = 1'b0;
  logic [31:0] jump_pc  = '0;
  logic        trap_en  = 1'b0;
  logic [31:0] trap_pc  = '0;
  logic        lsu_req_valid;
  logic        lsu_req_ready = 1'b0;
  logic        lsu_rsp_valid = 1'b0;
  logic        lsu_rsp_err   = 1'b0;
  logic        gpr_w_gate;
  logic        csr_w_gate;
  logic        commit;
  logic        halted;
  logic [2:0]  err_cause;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_pc;

  typedef struct {
    int          d1;    // cycles ifu_req_ready stays low
    int          d2;    // cycles before ifu_rsp_valid
    bit          ferr;
    bit          mem;
    bit          st;
    int          d3;    // cycles lsu_req_ready stays low
    int          d4;    // cycles before lsu_rsp_valid
    bit          lerr;
    bit          jmp;
    logic [31:0] jpc;
    bit          trp;
    logic [31:0] tpc;
  } instr_t;

  ysyx_23060240_mc_ctrl #(
    .XLEN          (32),
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_req_ready (ifu_req_ready),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .ifu_rsp_err   (ifu_rsp_err),
    .inst          (inst),
    .pc            (pc),
    .is_load       (is_load),
    .is_store      (is_store),
    .jump_en       (jump_en),
    .jump_pc       (jump_pc),
    .trap_en       (trap_en),
    .trap_pc       (trap_pc),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_err   (lsu_rsp_err),
    .gpr_w_gate    (gpr_w_gate),
    .csr_w_gate    (csr_w_gate),
    .commit        (commit),
    .halted        (halted),
    .err_cause     (err_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decode/redirect inputs are only meaningful in EXEC and WB; scramble them
  // elsewhere so that sampling in the wrong state shows up.
  task automatic noise();
    is_load  = 1'($urandom_range(0, 1));
    is_store = 1'($urandom_range(0, 1));
    jump_en  = 1'($urandom_range(0, 1));
    trap_en  = 1'($urandom_range(0, 1));
    jump_pc  = $urandom;
    trap_pc  = $urandom;
  endtask

  task automatic clear_bus();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_err   = 1'b0;
  endtask

  task automatic quiet_checks(input string ph);
    check({ph, "_gpr_gate"}, gpr_w_gate, 0);
    check({ph, "_csr_gate"}, csr_w_gate, 0);
    check({ph, "_commit"},   commit,     0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    clear_bus();
    noise();
    #1;
    check("rst_ifu_valid", ifu_req_valid, 0);
    check("rst_lsu_valid", lsu_req_valid, 0);
    quiet_checks("rst");
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_ifu_valid", ifu_req_valid, 0);
      check("rst_lsu_valid", lsu_req_valid, 0);
      quiet_checks("rst");
    end
    check("rst_pc",     pc,        RST_PC);
    check("rst_inst",   inst,      32'h0000_0013);
    check("rst_halted", halted,    0);
    check("rst_cause",  err_cause, 0);
    model_pc = RST_PC;
    rst = 1'b1;
    #1;
  endtask

  // Sit in HALT for 50 cycles: no requests, no writes, status held.
  task automatic expect_halt(input logic [2:0] cause);
    for (int i = 0; i < 50; i++) begin
      check("halt_flag",  halted,        1);
      check("halt_cause", err_cause,     {29'd0, cause});
      check("halt_ifu",   ifu_req_valid, 0);
      check("halt_lsu",   lsu_req_valid, 0);
      quiet_checks("halt");
      noise();
      ifu_req_ready = 1'($urandom_range(0, 1));
      ifu_rsp_valid = 1'($urandom_range(0, 1));
      lsu_req_ready = 1'($urandom_range(0, 1));
      lsu_rsp_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    clear_bus();
  endtask

  function automatic instr_t plain();
    instr_t t;
    t = '{d1: 0, d2: 0, ferr: 0, mem: 0, st: 0, d3: 0, d4: 0, lerr: 0,
          jmp: 0, jpc: 32'h0, trp: 0, tpc: 32'h0};
    return t;
  endfunction

  // Walks one instruction from its first FETCH_REQ cycle. Entered and left
  // at a falling edge; on a normal retire it leaves in the next FETCH_REQ.
  task automatic run_instr(input instr_t t, output bit ended_halt);
    logic [31:0] word;
    logic [31:0] nxt;
    word = $urandom;
    ended_halt = 1'b0;

    for (int i = 0; i <= t.d1; i++) begin
      check("freq_valid", ifu_req_valid, 1);
      check("freq_addr",  ifu_req_addr,  model_pc);
      check("freq_lsu",   lsu_req_valid, 0);
      quiet_checks("freq");
      noise();
      ifu_req_ready = (i == t.d1);
      ifu_rsp_valid = 1'($urandom_range(0, 1));
      ifu_rsp_err   = 1'($urandom_range(0, 1));
      ifu_rsp_data  = $urandom;
      @(negedge clk);
    end
    ifu_req_ready = 1'b0;

    for (int i = 0; i <= t.d2; i++) begin
      check("fwait_valid", ifu_req_valid, 0);
      check("fwait_pc",    pc,            model_pc);
      quiet_checks("fwait");
      noise();
      ifu_rsp_valid = (i == t.d2);
      ifu_rsp_err   = (i == t.d2) && t.ferr;
      ifu_rsp_data  = (i == t.d2) ? word : $urandom;
      @(negedge clk);
    end
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    if (t.ferr) begin
      expect_halt(3'd1);
      ended_halt = 1'b1;
      return;
    end

    check("exec_inst", inst, word);
    check("exec_pc",   pc,   model_pc);
    check("exec_ifu",  ifu_req_valid, 0);
    quiet_checks("exec");
    noise();
    is_load  = t.mem && !t.st;
    is_store = t.mem && t.st;
    @(negedge clk);

    if (t.mem) begin
      for (int i = 0; i <= t.d3; i++) begin
        check("mreq_valid", lsu_req_valid, 1);
        check("mreq_ifu",   ifu_req_valid, 0);
        check("mreq_inst",  inst,          word);
        quiet_checks("mreq");
        noise();
        lsu_req_ready = (i == t.d3);
        @(negedge clk);
      end
      lsu_req_ready = 1'b0;
      for (int i = 0; i <= t.d4; i++) begin
        check("mwait_lsu", lsu_req_valid, 0);
        check("mwait_pc",  pc,            model_pc);
        quiet_checks("mwait");
        noise();
        lsu_rsp_valid = (i == t.d4);
        lsu_rsp_err   = (i == t.d4) && t.lerr;
        @(negedge clk);
      end
      lsu_rsp_valid = 1'b0;
      lsu_rsp_err   = 1'b0;
      if (t.lerr) begin
        expect_halt(3'd2);
        ended_halt = 1'b1;
        return;
      end
    end

    check("wb_commit",   commit,     1);
    check("wb_gpr_gate", gpr_w_gate, 1);
    check("wb_csr_gate", csr_w_gate, 1);
    check("wb_pc",       pc,         model_pc);
    check("wb_inst",     inst,       word);
    check("wb_ifu",      ifu_req_valid, 0);
    noise();
    jump_en = t.jmp;
    jump_pc = t.jpc;
    trap_en = t.trp;
    trap_pc = t.tpc;
    if (t.trp)      nxt = t.tpc;
    else if (t.jmp) nxt = t.jpc;
    else            nxt = model_pc + 32'd4;
    model_pc = nxt;
    @(negedge clk);
    noise();

    if (nxt[1:0] != 2'b00) begin
      check("misalign_pc", pc, nxt);
      expect_halt(3'd4);
      ended_halt = 1'b1;
    end
  endtask

  initial begin
    instr_t t;
    bit     h;

    // Reset held for 3 cycles, then three zero-wait nops.
    @(negedge clk);
    do_reset(3);
    for (int i = 0; i < 3; i++) run_instr(plain(), h);

    // Stalled fetch request (5) and delayed load response (7).
    t = plain(); t.d1 = 5; t.mem = 1; t.d4 = 7;
    run_instr(t, h);

    // All bus phases stretched to the last cycle before the timeout fires.
    t = plain(); t.d1 = 7; t.d2 = 7; t.mem = 1; t.st = 1; t.d3 = 7; t.d4 = 7;
    run_instr(t, h);

    // Redirect priority: trap over jump, then jump alone.
    t = plain(); t.trp = 1; t.tpc = 32'h8000_0100; t.jmp = 1; t.jpc = 32'h8000_0200;
    run_instr(t, h);
    t = plain(); t.jmp = 1; t.jpc = 32'h8000_0200;
    run_instr(t, h);

    // Sequential PC wraps at the top of the address space.
    t = plain(); t.jmp = 1; t.jpc = 32'hFFFF_FFFC;
    run_instr(t, h);
    run_instr(plain(), h);
    check("wrap_pc", pc, 32'h0000_0000);
    t = plain(); t.jmp = 1; t.jpc = RST_PC;
    run_instr(t, h);

    // Randomized mix of stalls, loads/stores and aligned redirects.
    for (int n = 0; n < 40; n++) begin
      t = plain();
      t.d1  = $urandom_range(0, TMO - 1);
      t.d2  = $urandom_range(0, TMO - 1);
      t.mem = 1'($urandom_range(0, 1));
      t.st  = 1'($urandom_range(0, 1));
      t.d3  = $urandom_range(0, TMO - 1);
      t.d4  = $urandom_range(0, TMO - 1);
      t.jmp = ($urandom_range(0, 3) == 0);
      t.jpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      t.trp = ($urandom_range(0, 7) == 0);
      t.tpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      run_instr(t, h);
      check("rand_no_halt", {31'd0, h}, 0);
    end

    // Fetch error on the second fetch.
    do_reset(2);
    run_instr(plain(), h);
    t = plain(); t.ferr = 1; t.d2 = 2;
    run_instr(t, h);

    // LSU error on a load.
    do_reset(2);
    run_instr(plain(), h);
    t = plain(); t.mem = 1; t.d4 = 3; t.lerr = 1;
    run_instr(t, h);

    // Misaligned jump target still retires, then halts.
    do_reset(2);
    t = plain(); t.jmp = 1; t.jpc = 32'h8000_0102;
    run_instr(t, h);

    // Fetch request never accepted: halts after exactly TMO cycles.
    do_reset(2);
    for (int i = 0; i < TMO; i++) begin
      check("tmo_valid",  ifu_req_valid, 1);
      check("tmo_halted", halted,        0);
      noise();
      @(negedge clk);
    end
    expect_halt(3'd3);

    // Reset asserted while a load is outstanding.
    do_reset(1);
    clear_bus();
    ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0000_2083;
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
    is_load  = 1'b1;
    is_store = 1'b0;
    @(negedge clk);
    check("mid_lsu_req", lsu_req_valid, 1);
    lsu_req_ready = 1'b1;
    @(negedge clk);
    lsu_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_lsu_valid", lsu_req_valid, 0);
    quiet_checks("mid");
    @(negedge clk);
    check("mid_pc",     pc,            RST_PC);
    check("mid_inst",   inst,          32'h0000_0013);
    check("mid_ifu",    ifu_req_valid, 0);
    check("mid_lsu",    lsu_req_valid, 0);
    quiet_checks("mid_post");
    model_pc = RST_PC;
    rst = 1'b1;
    #1;
    run_instr(plain(), h);
    run_instr(plain(), h);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
